// File: rtl/serial_seq_tx.sv
// serial_seq_tx
// Serial sequence transmitter feeding the lab's sequence-detector FSMs.
// A frame of 1..WIDTH bits is taken from `data` and sent LSB-first on `w`,
// one bit per clock. After the frame, `w` is held at IDLE_LEVEL for GAP
// cycles, and then `done` pulses for one cycle.
//
// Parameters:
//   WIDTH      maximum frame length in bits (2..16)
//   GAP        idle cycles inserted after every frame (0..15)
//   IDLE_LEVEL level driven on `w` whenever no frame bit is on the line
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   start  in   frame request, sampled only while ready=1
//   data   in   frame bits, bit 0 sent first
//   len    in   number of bits to send, legal range 1..WIDTH
//   w      out  serial line (registered, glitch-free)
//   valid  out  high in every cycle in which `w` carries a frame bit
//   ready  out  high while idle and able to accept `start`
//   done   out  one-cycle pulse in the first idle cycle after a frame
//   err    out  one-cycle pulse after a start with an illegal `len`
//   state  out  current FSM state code (debug)

module serial_seq_tx #(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [4:0]       len,
  output logic             w,
  output logic             valid,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SHIFT  = 2'b01,
    S_GAP    = 2'b10,
    S_UNUSED = 2'b11
  } state_t;

  localparam logic [4:0] MAX_LEN  = 5'(WIDTH);
  localparam bit         HAS_GAP  = (GAP > 0);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           cur_state;
  state_t           nxt_state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [4:0]       bit_cnt;
  logic [4:0]       bit_cnt_n;
  logic [3:0]       gap_cnt;
  logic [3:0]       gap_cnt_n;
  logic             w_q;
  logic             w_n;
  logic             valid_q;
  logic             valid_n;
  logic             done_q;
  logic             done_n;
  logic             err_q;
  logic             err_n;
  logic             len_ok;

  assign len_ok = (len != 5'd0) && (len <= MAX_LEN);

  // State and datapath registers. Reset aborts any frame in flight: the
  // line returns to the idle level at once and no done is produced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      w_q       <= IDLE_LEVEL;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      w_q       <= w_n;
      valid_q   <= valid_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  // Next-state and next-output logic. The line value for the coming cycle
  // is computed here and registered, so `w` never glitches. On acceptance,
  // bit 0 goes straight to the line and the shift register keeps the rest.
  // bit_cnt holds the number of frame bits still to be shown, counting the
  // bit currently on the line.
  always_comb begin
    nxt_state = cur_state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    w_n       = IDLE_LEVEL;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (cur_state)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            nxt_state = S_SHIFT;
            w_n       = data[0];
            valid_n   = 1'b1;
            shreg_n   = data >> 1;
            bit_cnt_n = len;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (bit_cnt == 5'd1) begin
          // Last bit is on the line now; either idle out the gap or finish.
          bit_cnt_n = 5'd0;
          if (HAS_GAP) begin
            nxt_state = S_GAP;
            gap_cnt_n = GAP_LOAD;
          end else begin
            nxt_state = S_IDLE;
            done_n    = 1'b1;
          end
        end else begin
          w_n       = shreg[0];
          valid_n   = 1'b1;
          shreg_n   = shreg >> 1;
          bit_cnt_n = bit_cnt - 5'd1;
        end
      end

      S_GAP: begin
        if (gap_cnt == 4'd0) begin
          nxt_state = S_IDLE;
          done_n    = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end

      default: begin
        // Unused encoding recovers to idle on the next edge.
        nxt_state = S_IDLE;
      end
    endcase
  end

  assign w     = w_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign err   = err_q;
  assign ready = (cur_state == S_IDLE);
  assign state = cur_state;

endmodule

// File: tb/tb_serial_seq_tx.sv
// tb_serial_seq_tx
// Directed testbench for serial_seq_tx (WIDTH=8, GAP=2, IDLE_LEVEL=0).
// Expected frame bits are queued when a start is driven and are popped as
// the transmitter puts them on the line.

module tb_serial_seq_tx;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic [4:0] len;
  logic       w;
  logic       valid;
  logic       ready;
  logic       done;
  logic       err;
  logic [1:0] state;

  int testCount = 0;
  int failCount = 0;
  bit expQ[$];

  serial_seq_tx #(
    .WIDTH(WIDTH),
    .GAP(GAP),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .data(data),
    .len(len),
    .w(w),
    .valid(valid),
    .ready(ready),
    .done(done),
    .err(err),
    .state(state)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a start request; legal lengths queue their bits, LSB first.
  task automatic applyStimulus(input logic [7:0] d, input logic [4:0] l);
    start = 1'b1;
    data  = d;
    len   = l;
    if (l >= 5'd1 && int'(l) <= WIDTH)
      for (int i = 0; i < int'(l); i++) expQ.push_back(d[i]);
  endtask

  // Follow a frame from its first bit to its done cycle. If ignoreAt is
  // non-zero, a new start with other data is raised in that frame cycle.
  // Returns positioned in the done cycle, with start low.
  task automatic drainFrame(input int nbits, input int ignoreAt, input logic [7:0] other);
    logic e;
    step();
    start = 1'b0;
    for (int c = 1; c <= nbits; c++) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
      end else begin
        e = 1'bx;
        testCount++;
        failCount++;
        $error("[TB] FAIL sb_underflow: observed empty queue expected a bit");
      end
      checkOutput("frame_valid", valid, 1'b1);
      checkOutput("frame_w", w, e);
      checkOutput("frame_ready", ready, 1'b0);
      checkOutput("frame_done", done, 1'b0);
      if (c == ignoreAt) begin
        start = 1'b1;
        data  = other;
        len   = 5'd8;
      end
      step();
      start = 1'b0;
    end
    for (int g = 0; g < GAP; g++) begin
      checkOutput("gap_valid", valid, 1'b0);
      checkOutput("gap_w", w, 1'b0);
      checkOutput("gap_done", done, 1'b0);
      step();
    end
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("done_ready", ready, 1'b1);
    checkOutput("done_valid", valid, 1'b0);
    checkWord("sb_empty", 32'(expQ.size()), 32'd0);
  endtask

  // One rejected request: err pulses the cycle after, nothing is sent.
  task automatic rejectCheck(input logic [4:0] l);
    applyStimulus(8'hFF, l);
    step();
    start = 1'b0;
    checkOutput("bad_err", err, 1'b1);
    checkOutput("bad_ready", ready, 1'b1);
    checkOutput("bad_valid", valid, 1'b0);
    step();
    checkOutput("bad_err_clear", err, 1'b0);
    checkOutput("bad_no_done", done, 1'b0);
    checkOutput("bad_valid2", valid, 1'b0);
    checkWord("bad_sb_empty", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    data  = 8'h00;
    len   = 5'd0;

    // Reset values
    step(); step(); step();
    checkOutput("rst_w", w, 1'b0);
    checkOutput("rst_valid", valid, 1'b0);
    checkOutput("rst_ready", ready, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkWord("rst_state", 32'(state), 32'd0);
    reset = 1'b1;
    step();
    checkOutput("post_rst_done", done, 1'b0);

    // Full 8-bit frame
    applyStimulus(8'b1011_0010, 5'd8);
    drainFrame(8, 0, 8'h00);
    step();
    checkOutput("full_done_clear", done, 1'b0);

    // Short frame followed back-to-back by a second frame
    applyStimulus(8'h05, 5'd3);
    drainFrame(3, 0, 8'h00);
    applyStimulus(8'h02, 5'd2);
    drainFrame(2, 0, 8'h00);
    step();
    checkOutput("b2b_done_clear", done, 1'b0);

    // Bad lengths
    rejectCheck(5'd0);
    rejectCheck(5'd9);

    // Start raised mid-frame is ignored
    applyStimulus(8'hC3, 5'd8);
    drainFrame(8, 4, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("ign_no_second_valid", valid, 1'b0);
      checkOutput("ign_ready", ready, 1'b1);
      checkOutput("ign_no_done", done, 1'b0);
    end

    // Single-bit frame
    applyStimulus(8'h01, 5'd1);
    drainFrame(1, 0, 8'h00);
    step();

    // Reset in cycle 3 of an 8-bit frame
    applyStimulus(8'hA5, 5'd8);
    step();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checkOutput("abort_valid", valid, 1'b1);
      checkOutput("abort_w", w, expQ.pop_front());
      if (c < 3) step();
    end
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_w_idle", w, 1'b0);
    checkOutput("abort_valid_low", valid, 1'b0);
    checkOutput("abort_ready", ready, 1'b1);
    checkWord("abort_state", 32'(state), 32'd0);
    expQ.delete();
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("abort_no_done", done, 1'b0);
      checkOutput("abort_no_valid", valid, 1'b0);
    end
    applyStimulus(8'h6E, 5'd5);
    drainFrame(5, 0, 8'h00);
    step();
    checkOutput("final_done_clear", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
